// File: rtl/alu_pkg.sv
// Opcode and FSM state definitions shared by the sequential ALU and its iterative core.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Shared iterative core: shift-add multiply (LSB first) or restoring divide (MSB first), one bit per step.
// Results are the post-step values, so the owner can register them on the same edge as the final step.
module iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // Multiply: acc_q is the running product. Divide: acc_q = {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   b_q;
  logic               mode_q;
  logic [WIDTH:0]     partial, diff;

  assign partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff    = partial - {1'b0, b_q};

  always_comb begin
    acc_d = acc_q;
    if (step) begin
      if (mode_q) begin
        if (partial >= {1'b0, b_q}) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                         acc_d = {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else if (b_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else if (load) begin
      mode_q  <= mode;
      b_q     <= b;
      mcand_q <= {{WIDTH{1'b0}}, a};
      acc_q   <= mode ? {{WIDTH{1'b0}}, a} : '0;
    end else if (step) begin
      acc_q <= acc_d;
      if (!mode_q) begin
        mcand_q <= mcand_q << 1;
        b_q     <= b_q >> 1;
      end
    end
  end

  assign product   = acc_d[WIDTH-1:0];
  assign quotient  = acc_d[WIDTH-1:0];
  assign remainder = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops and divide-by-zero answer in 1 cycle, MUL/DIV/REM in WIDTH+1.
// No queueing: start is only taken in IDLE, so requests while busy or in DONE are dropped.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       aluControl,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q;
  logic             rem_q;
  logic [WIDTH-1:0] single_res, iter_res, product, quotient, remainder;
  logic             accept, is_mul, is_divrem, div0, iter_load, last_step;

  assign accept    = start && (state_q == S_IDLE);
  assign is_mul    = (aluControl == OP_MUL);
  assign is_divrem = (aluControl == OP_DIV) || (aluControl == OP_REM);
  assign div0      = is_divrem && (input2 == '0);
  assign iter_load = accept && (is_mul || (is_divrem && !div0));
  assign last_step = (counter_q == CNT_W'(WIDTH - 1));
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign iter_res  = (state_q == S_MUL) ? product : (rem_q ? remainder : quotient);

  iter_muldiv #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (iter_load),
    .mode      (is_divrem),
    .a         (input1),
    .b         (input2),
    .step      (busy),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // DIV/REM only reach this path with a zero divisor, so their entries are the fault answers.
  always_comb begin
    single_res = '0;
    case (aluControl)
      OP_ADD: single_res = input1 + input2;
      OP_SUB: single_res = input1 - input2;
      OP_NOT: single_res = ~input1;
      OP_SHL: single_res = (input2 >= WIDTH'(WIDTH)) ? '0 : (input1 << input2);
      OP_SHR: single_res = (input2 >= WIDTH'(WIDTH)) ? '0 : (input1 >> input2);
      OP_AND: single_res = input1 & input2;
      OP_OR:  single_res = input1 | input2;
      OP_SLT: single_res = WIDTH'(input1 < input2);
      OP_DIV: single_res = '1;
      OP_REM: single_res = input1;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul)                state_d = S_MUL;
        else if (accept && is_divrem && !div0) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last_step) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Out         <= '0;
      zero        <= 1'b0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      counter_q   <= '0;
      rem_q       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        counter_q <= '0;
        rem_q     <= (aluControl == OP_REM);
        if (!iter_load) begin
          Out         <= single_res;
          zero        <= (single_res == '0);
          div_by_zero <= div0;
          valid       <= 1'b1;
        end
      end else if (busy) begin
        counter_q <= counter_q + CNT_W'(1);
        if (last_step) begin
          Out         <= iter_res;
          zero        <= (iter_res == '0);
          div_by_zero <= 1'b0;
          valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=16 and WIDTH=8: directed table, handshake corner sequences, random vs model.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [3:0]  op16, op8;
  logic [15:0] a16, b16, out16;
  logic [7:0]  a8, b8, out8;
  logic        zero16, valid16, busy16, dbz16;
  logic        zero8, valid8, busy8, dbz8;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(16)) u_alu16 (
    .clk(clk), .rst(rst), .start(start16), .input1(a16), .input2(b16), .aluControl(op16),
    .Out(out16), .zero(zero16), .valid(valid16), .busy(busy16), .div_by_zero(dbz16)
  );

  seq_alu #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst), .start(start8), .input1(a8), .input2(b8), .aluControl(op8),
    .Out(out8), .zero(zero8), .valid(valid8), .busy(busy8), .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(string n, logic [3:0] op, logic [15:0] a, logic [15:0] b,
                                  logic [15:0] o, logic d, int l);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.out = o; v.dbz = d; v.lat = l;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, {div_by_zero, result}.
  function automatic logic [16:0] model(int w, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    longint unsigned mask, x, y, r, wl;
    logic d;
    wl = longint'(w);
    mask = (64'd1 << w) - 64'd1;
    x = {48'd0, a}; y = {48'd0, b}; r = 0; d = 1'b0;
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_NOT: r = ~x;
      OP_SHL: r = (y >= wl) ? 0 : (x << y);
      OP_SHR: r = (y >= wl) ? 0 : (x >> y);
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_SLT: r = (x < y) ? 1 : 0;
      OP_MUL: r = x * y;
      OP_DIV: if (y == 0) begin r = mask; d = 1'b1; end else r = x / y;
      OP_REM: if (y == 0) begin r = x;    d = 1'b1; end else r = x % y;
      default: r = 0;
    endcase
    r = r & mask;
    return {d, r[15:0]};
  endfunction

  function automatic int lat_of(int w, logic [3:0] op, logic [15:0] b);
    if (op == OP_MUL || ((op == OP_DIV || op == OP_REM) && b != 16'd0)) return w + 1;
    return 1;
  endfunction

  task automatic do_op(input int w, input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_out, input logic exp_dbz,
                       input int exp_lat);
    int lat;
    logic v, z, d;
    logic [15:0] o;
    @(negedge clk);
    if (w == 8) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else        begin start16 = 1'b1; op16 = op; a16 = a; b16 = b; end
    @(posedge clk);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
    lat = 0; v = 1'b0;
    while (!v && lat < 40) begin
      @(negedge clk);
      lat++;
      v = (w == 8) ? valid8 : valid16;
    end
    o = (w == 8) ? {8'h00, out8} : out16;
    z = (w == 8) ? zero8 : zero16;
    d = (w == 8) ? dbz8 : dbz16;
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_out"}, {16'h0, o}, {16'h0, exp_out});
    check({name, "_zero"}, {31'h0, z}, {31'h0, exp_out == 16'h0});
    check({name, "_dbz"}, {31'h0, d}, {31'h0, exp_dbz});
    @(negedge clk);
    v = (w == 8) ? valid8 : valid16;
    check({name, "_pulse"}, {31'h0, v}, 32'h0);
  endtask

  initial begin
    int pulses, first, busy_cnt, lat;
    logic [16:0] m;
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    logic [15:0] out_at_valid;

    rst = 1'b0; start16 = 1'b0; start8 = 1'b0;
    op16 = '0; a16 = '0; b16 = '0; op8 = '0; a8 = '0; b8 = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_out", {16'h0, out16}, 32'h0);
    check("rst_zero", {31'h0, zero16}, 32'h0);
    check("rst_valid", {31'h0, valid16}, 32'h0);
    check("rst_busy", {31'h0, busy16}, 32'h0);
    check("rst_dbz", {31'h0, dbz16}, 32'h0);
    check("rst_out8", {24'h0, out8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    add_vec("add_wrap",  OP_ADD, 16'hffff, 16'h0001, 16'h0000, 1'b0, 1);
    add_vec("sub_wrap",  OP_SUB, 16'h0005, 16'h0007, 16'hfffe, 1'b0, 1);
    add_vec("not",       OP_NOT, 16'h00ff, 16'h1234, 16'hff00, 1'b0, 1);
    add_vec("shl",       OP_SHL, 16'h0001, 16'd4,    16'h0010, 1'b0, 1);
    add_vec("shl_16",    OP_SHL, 16'h0001, 16'd16,   16'h0000, 1'b0, 1);
    add_vec("shr",       OP_SHR, 16'h8000, 16'd15,   16'h0001, 1'b0, 1);
    add_vec("shr_big",   OP_SHR, 16'hffff, 16'd40,   16'h0000, 1'b0, 1);
    add_vec("and",       OP_AND, 16'hf0f0, 16'hff00, 16'hf000, 1'b0, 1);
    add_vec("or",        OP_OR,  16'hf0f0, 16'h0f00, 16'hfff0, 1'b0, 1);
    add_vec("slt_t",     OP_SLT, 16'd3,    16'd7,    16'h0001, 1'b0, 1);
    add_vec("slt_f",     OP_SLT, 16'd7,    16'd3,    16'h0000, 1'b0, 1);
    add_vec("slt_eq",    OP_SLT, 16'd5,    16'd5,    16'h0000, 1'b0, 1);
    add_vec("mul",       OP_MUL, 16'd300,  16'd300,  16'h5f90, 1'b0, 17);
    add_vec("mul_max",   OP_MUL, 16'hffff, 16'hffff, 16'h0001, 1'b0, 17);
    add_vec("div",       OP_DIV, 16'd1000, 16'd7,    16'd142,  1'b0, 17);
    add_vec("rem",       OP_REM, 16'd1000, 16'd7,    16'd6,    1'b0, 17);
    add_vec("div_small", OP_DIV, 16'd5,    16'd9,    16'd0,    1'b0, 17);
    add_vec("rem_small", OP_REM, 16'd5,    16'd9,    16'd5,    1'b0, 17);
    add_vec("div_max",   OP_DIV, 16'hffff, 16'd1,    16'hffff, 1'b0, 17);
    add_vec("div0",      OP_DIV, 16'd1234, 16'd0,    16'hffff, 1'b1, 1);
    add_vec("rem0",      OP_REM, 16'd1234, 16'd0,    16'd1234, 1'b1, 1);
    add_vec("bad_op",    4'hf,   16'd1,    16'd2,    16'h0000, 1'b0, 1);
    foreach (tbl[i])
      do_op(16, tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].dbz, tbl[i].lat);

    // Back-to-back single-cycle starts, one per cycle.
    @(negedge clk);
    start16 = 1'b1; op16 = OP_ADD; a16 = 16'hffff; b16 = 16'h0001;
    @(negedge clk);
    check("b2b_add_vld", {31'h0, valid16}, 32'h1);
    check("b2b_add_out", {16'h0, out16}, 32'h0);
    check("b2b_add_zero", {31'h0, zero16}, 32'h1);
    op16 = OP_SLT; a16 = 16'd3; b16 = 16'd7;
    @(negedge clk);
    check("b2b_slt_vld", {31'h0, valid16}, 32'h1);
    check("b2b_slt_out", {16'h0, out16}, 32'h1);
    op16 = OP_SHL; a16 = 16'h0001; b16 = 16'd16;
    @(negedge clk);
    check("b2b_shl_vld", {31'h0, valid16}, 32'h1);
    check("b2b_shl_out", {16'h0, out16}, 32'h0);
    check("b2b_shl_zero", {31'h0, zero16}, 32'h1);
    start16 = 1'b0;
    @(negedge clk);
    check("b2b_idle_vld", {31'h0, valid16}, 32'h0);

    // MUL with a stray start at cycle 5 that must be dropped.
    @(negedge clk);
    start16 = 1'b1; op16 = OP_MUL; a16 = 16'd300; b16 = 16'd300;
    @(posedge clk);
    #1;
    start16 = 1'b0; a16 = 16'h1111; b16 = 16'h2222;
    pulses = 0; first = 0; busy_cnt = 0; out_at_valid = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (valid16) begin
        pulses++;
        if (first == 0) begin first = c; out_at_valid = out16; end
      end
      if (busy16) busy_cnt++;
      if (c == 5) begin start16 = 1'b1; op16 = OP_ADD; a16 = 16'd1; b16 = 16'd1; end
      else start16 = 1'b0;
    end
    check("busyign_lat", 32'(first), 32'd17);
    check("busyign_pulses", 32'(pulses), 32'd1);
    check("busyign_busy_cycles", 32'(busy_cnt), 32'd16);
    check("busyign_out", {16'h0, out_at_valid}, 32'h5f90);

    // start raised during DONE is only taken from the following IDLE cycle.
    @(negedge clk);
    start16 = 1'b1; op16 = OP_MUL; a16 = 16'd3; b16 = 16'd4;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    lat = 0;
    while (!valid16 && lat < 40) begin @(negedge clk); lat++; end
    check("done_mul_lat", 32'(lat), 32'd17);
    check("done_mul_out", {16'h0, out16}, 32'd12);
    check("done_busy", {31'h0, busy16}, 32'h0);
    start16 = 1'b1; op16 = OP_ADD; a16 = 16'd1; b16 = 16'd1;
    @(negedge clk);
    check("done_start_ignored", {31'h0, valid16}, 32'h0);
    @(negedge clk);
    check("done_start_taken", {31'h0, valid16}, 32'h1);
    check("done_start_out", {16'h0, out16}, 32'd2);
    start16 = 1'b0;

    // Reset in the middle of a MUL.
    @(negedge clk);
    start16 = 1'b1; op16 = OP_MUL; a16 = 16'd300; b16 = 16'd300;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_busy_before", {31'h0, busy16}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_out", {16'h0, out16}, 32'h0);
    check("rstmid_busy", {31'h0, busy16}, 32'h0);
    check("rstmid_valid", {31'h0, valid16}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (valid16) pulses++;
    end
    check("rstmid_no_pulse", 32'(pulses), 32'h0);
    do_op(16, "rst_recover", OP_ADD, 16'd5, 16'd6, 16'd11, 1'b0, 1);

    do_op(8, "w8_mul_15x17", OP_MUL, 16'd15, 16'd17, 16'h00ff, 1'b0, 9);

    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      if (rop == OP_SHL || rop == OP_SHR) rb = 16'($urandom_range(0, 20));
      else if ((rop == OP_DIV || rop == OP_REM) && $urandom_range(0, 7) == 0) rb = 16'd0;
      else rb = 16'($urandom);
      m = model(16, rop, ra, rb);
      do_op(16, "rnd16", rop, ra, rb, m[15:0], m[16], lat_of(16, rop, rb));
    end

    for (int i = 0; i < 1000; i++) begin
      rop = 4'(8 + $urandom_range(0, 2));
      ra = 16'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
      m = model(8, rop, ra, rb);
      do_op(8, "rnd8", rop, ra, rb, m[15:0], m[16], lat_of(8, rop, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
